instruction_decode: RTL and testbench
=====================================

Name: instruction_decode

Overview:
- Decode stage directly upstream of the execute stage.
- Accepts 16-bit instruction words from fetch over a valid/ready handshake.
- Classifies each word and registers the operation number and operand fields the execute stage consumes: operationnumber, destination, source_1, source_2, unsigned_1/2/3.
- Tracks 32-bit (two-word) instructions with a small FSM. This revision does not support 32-bit forms: they are consumed and reported illegal.

Parameters:
WORD_W, 16, instruction word width
OPN_W, 6, operationnumber width
PC_W, 16, program counter width

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous pipeline flush (branch redirect)
stall  in  1  downstream hold; outputs frozen, no accept
instr_valid  in  1  fetch word valid
instr_word  in  16  instruction word
instr_pc  in  16  address of instr_word
instr_ready  out  1  decode can accept this cycle
dec_valid  out  1  registered outputs hold a real instruction
operationnumber  out  6  execute op code (0 = no operation)
destination  out  3  bits[8:6]
source_1  out  3  bits[5:3]
source_2  out  3  bits[2:0]
unsigned_1  out  3  bits[2:0]
unsigned_2  out  6  bits[5:0]
unsigned_3  out  9  bits[8:0]
dec_pc  out  16  pc of decoded instruction (first word for 32-bit)
illegal  out  1  decoded instruction illegal; valid with dec_valid

Behaviour:
- Word format: bit15 = long flag; [14:13] = class; [12:9] = opcode; [8:6], [5:3], [2:0] = fields.
- Reset: all outputs 0, state FIRST, instr_ready 0 during reset.
- instr_ready = !stall && !flush (combinational). Accept = instr_valid && instr_ready.
- Priority per edge: reset > flush > stall > accept.
- Latency: an accepted short word appears on the outputs at the next edge (1 cycle).
- Invariant: dec_valid=0 forces operationnumber=0 and illegal=0. Execute treats bubbles as no operation.
- Stall: every output register and the FSM hold, including a pending first word.
- No accept and no stall: bubble next cycle. dec_valid=0, operationnumber=0; field outputs hold.
- FSM FIRST, short word (bit15=0): decode it.
  - Class 00: operationnumber = opcode (0..15: nop, add, sub, and, or, xor, asr, lsl, lsr, mov, addi, subi, asri, lsli, lsri, movi).
  - Class 01, opcode 0: operationnumber 16 (load byte).
  - Class 01, opcode 4: operationnumber 17 (load word).
  - Other class 01 opcodes, and classes 10/11: operationnumber 0, illegal=1, dec_valid=1.
  - Field outputs always take raw slices, even when illegal.
- FSM FIRST, long word (bit15=1): latch instr_pc, go to SECOND, emit a bubble.
- FSM SECOND, accepted word: emit dec_valid=1, operationnumber 0, illegal=1, dec_pc = latched pc; return to FIRST. The word's bit15 is ignored.
- FSM SECOND, no valid word: stay in SECOND, emit a bubble.
- Flush in any state: next edge gives state FIRST, dec_valid 0, operationnumber 0, illegal 0. The word presented that cycle is dropped; a latched first word is discarded.
- Flush and stall together: flush wins.
- Reset mid-long-instruction: identical to flush, plus all outputs cleared.

Decomposition:
- Package aap_decode_pkg:
  - class codes
  - operationnumber constants 0..17
  - FSM state enum (FIRST, SECOND)
  - field bit-position constants
- One combinational sub-module aap_op_map: word -> operationnumber and illegal. Instantiated once; the registers and FSM stay in instruction_decode.

Test Plan:
- Reset, then 0x02CA valid at pc 0x0010 with no stall -> next cycle dec_valid=1, op 1, destination 3, source_1 1, source_2 2, dec_pc 0x0010, illegal 0.
- 0x1F6A -> op 15, destination 5, unsigned_2 0x2A, unsigned_3 0x16A. Next cycle instr_valid=0 -> dec_valid 0, op 0.
- 0x28A1 -> op 17, destination 2, source_1 4, unsigned_1 1. 0x4000 -> op 0, illegal 1, dec_valid 1.
- 0x8000 at pc 0x20, then 0x8000 at pc 0x21 -> first cycle is a bubble; next output is dec_valid 1, illegal 1, op 0, dec_pc 0x0020.
- 0x02CA decoded, then stall high 3 cycles with 0x1F6A presented -> outputs hold op 1, instr_ready 0. After stall falls, op 15 appears 1 cycle later.
- 0x8000 accepted, then flush together with 0x8000 -> dec_valid 0, state FIRST. A following 0x02CA decodes normally as op 1.

Source files
------------

// File: rtl/aap_decode_pkg.sv
// Shared constants for the AAP decode stage: word layout, class codes,
// execute op numbers and the long-instruction tracking states.
package aap_decode_pkg;

    localparam int WORD_W = 16;
    localparam int OPN_W  = 6;
    localparam int PC_W   = 16;

    // Instruction word bit positions
    localparam int LONG_BIT  = 15;
    localparam int CLASS_HI  = 14;
    localparam int CLASS_LO  = 13;
    localparam int OPC_HI    = 12;
    localparam int OPC_LO    = 9;
    localparam int DST_HI    = 8;
    localparam int DST_LO    = 6;
    localparam int SRC1_HI   = 5;
    localparam int SRC1_LO   = 3;
    localparam int SRC2_HI   = 2;
    localparam int SRC2_LO   = 0;
    localparam int FIELD_W   = DST_HI + 1;

    typedef enum logic [1:0] {
        CLASS_ALU  = 2'b00,
        CLASS_MEM  = 2'b01,
        CLASS_RSV2 = 2'b10,
        CLASS_RSV3 = 2'b11
    } class_t;

    localparam logic [3:0] MEM_LDB = 4'd0;
    localparam logic [3:0] MEM_LDW = 4'd4;

    localparam logic [OPN_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OPN_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OPN_W-1:0] OP_SUB  = 6'd2;
    localparam logic [OPN_W-1:0] OP_AND  = 6'd3;
    localparam logic [OPN_W-1:0] OP_OR   = 6'd4;
    localparam logic [OPN_W-1:0] OP_XOR  = 6'd5;
    localparam logic [OPN_W-1:0] OP_ASR  = 6'd6;
    localparam logic [OPN_W-1:0] OP_LSL  = 6'd7;
    localparam logic [OPN_W-1:0] OP_LSR  = 6'd8;
    localparam logic [OPN_W-1:0] OP_MOV  = 6'd9;
    localparam logic [OPN_W-1:0] OP_ADDI = 6'd10;
    localparam logic [OPN_W-1:0] OP_SUBI = 6'd11;
    localparam logic [OPN_W-1:0] OP_ASRI = 6'd12;
    localparam logic [OPN_W-1:0] OP_LSLI = 6'd13;
    localparam logic [OPN_W-1:0] OP_LSRI = 6'd14;
    localparam logic [OPN_W-1:0] OP_MOVI = 6'd15;
    localparam logic [OPN_W-1:0] OP_LDB  = 6'd16;
    localparam logic [OPN_W-1:0] OP_LDW  = 6'd17;

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } state_t;

endpackage

// File: rtl/instruction_decode_if.sv
// Fetch-to-decode handshake plus the decoded bundle presented to execute.
interface instruction_decode_if
    import aap_decode_pkg::*;
#(
    parameter int IF_WORD_W = WORD_W,
    parameter int IF_OPN_W  = OPN_W,
    parameter int IF_PC_W   = PC_W
);
    logic                 instr_valid;
    logic [IF_WORD_W-1:0] instr_word;
    logic [IF_PC_W-1:0]   instr_pc;
    logic                 instr_ready;

    logic                 dec_valid;
    logic [IF_OPN_W-1:0]  operationnumber;
    logic [2:0]           destination;
    logic [2:0]           source_1;
    logic [2:0]           source_2;
    logic [2:0]           unsigned_1;
    logic [5:0]           unsigned_2;
    logic [8:0]           unsigned_3;
    logic [IF_PC_W-1:0]   dec_pc;
    logic                 illegal;

    // Environment side: fetch drives words, execute consumes the bundle
    modport master (
        output instr_valid, instr_word, instr_pc,
        input  instr_ready,
        input  dec_valid, operationnumber, destination, source_1, source_2,
        input  unsigned_1, unsigned_2, unsigned_3, dec_pc, illegal
    );

    modport slave (
        input  instr_valid, instr_word, instr_pc,
        output instr_ready,
        output dec_valid, operationnumber, destination, source_1, source_2,
        output unsigned_1, unsigned_2, unsigned_3, dec_pc, illegal
    );
endinterface

// File: rtl/aap_op_map.sv
// Combinational classification of a short instruction word's class/opcode
// into an execute op number and an illegal flag.
module aap_op_map
    import aap_decode_pkg::*;
(
    input  logic [LONG_BIT:OPC_LO] head,
    output logic [OPN_W-1:0]       op,
    output logic                   illegal
);
    class_t     cls;
    logic [3:0] opc;

    always_comb begin
        cls     = class_t'(head[CLASS_HI:CLASS_LO]);
        opc     = head[OPC_HI:OPC_LO];
        op      = OP_NOP;
        illegal = 1'b0;
        if (head[LONG_BIT]) begin
            // Two-word forms are unsupported in this revision
            illegal = 1'b1;
        end else begin
            case (cls)
                CLASS_ALU: op = {2'b00, opc};
                CLASS_MEM: begin
                    if (opc == MEM_LDB)      op = OP_LDB;
                    else if (opc == MEM_LDW) op = OP_LDW;
                    else                     illegal = 1'b1;
                end
                default:   illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/instruction_decode.sv
// Decode stage: registers op number and raw operand slices for execute, and
// swallows two-word instructions as illegal using a FIRST/SECOND tracker.
module instruction_decode
    import aap_decode_pkg::*;
#(
    parameter int WORD_W_P = WORD_W,
    parameter int OPN_W_P  = OPN_W,
    parameter int PC_W_P   = PC_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 stall,
    instruction_decode_if.slave  bus
);
    state_t               state_reg, state_next;
    logic                 dec_valid_reg, dec_valid_next;
    logic [OPN_W_P-1:0]   op_reg, op_next;
    logic                 illegal_reg, illegal_next;
    logic [PC_W_P-1:0]    pc_reg, pc_next;
    logic [PC_W_P-1:0]    pend_pc_reg, pend_pc_next;
    logic [FIELD_W-1:0]   field_reg, field_next;

    logic                 ready;
    logic                 accept;
    logic [OPN_W-1:0]     map_op;
    logic                 map_illegal;

    aap_op_map u_op_map (
        .head    (bus.instr_word[LONG_BIT:OPC_LO]),
        .op      (map_op),
        .illegal (map_illegal)
    );

    assign ready  = !reset && !stall && !flush;
    assign accept = bus.instr_valid && ready;

    always_comb begin
        state_next     = state_reg;
        dec_valid_next = dec_valid_reg;
        op_next        = op_reg;
        illegal_next   = illegal_reg;
        pc_next        = pc_reg;
        pend_pc_next   = pend_pc_reg;
        field_next     = field_reg;

        if (flush) begin
            state_next     = FIRST;
            dec_valid_next = 1'b0;
            op_next        = '0;
            illegal_next   = 1'b0;
        end else if (!stall) begin
            // Anything not producing an instruction below is a bubble
            dec_valid_next = 1'b0;
            op_next        = '0;
            illegal_next   = 1'b0;
            if (accept) begin
                case (state_reg)
                    FIRST: begin
                        if (bus.instr_word[LONG_BIT]) begin
                            state_next   = SECOND;
                            pend_pc_next = bus.instr_pc;
                        end else begin
                            dec_valid_next = 1'b1;
                            op_next        = map_op;
                            illegal_next   = map_illegal;
                            pc_next        = bus.instr_pc;
                            field_next     = bus.instr_word[DST_HI:0];
                        end
                    end
                    SECOND: begin
                        state_next     = FIRST;
                        dec_valid_next = 1'b1;
                        illegal_next   = 1'b1;
                        pc_next        = pend_pc_reg;
                        field_next     = bus.instr_word[DST_HI:0];
                    end
                    default: state_next = FIRST;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= FIRST;
            dec_valid_reg <= 1'b0;
            op_reg        <= '0;
            illegal_reg   <= 1'b0;
            pc_reg        <= '0;
            pend_pc_reg   <= '0;
            field_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            dec_valid_reg <= dec_valid_next;
            op_reg        <= op_next;
            illegal_reg   <= illegal_next;
            pc_reg        <= pc_next;
            pend_pc_reg   <= pend_pc_next;
            field_reg     <= field_next;
        end
    end

    assign bus.instr_ready     = ready;
    assign bus.dec_valid       = dec_valid_reg;
    assign bus.operationnumber = op_reg;
    assign bus.illegal         = illegal_reg;
    assign bus.dec_pc          = pc_reg;
    assign bus.destination     = field_reg[DST_HI:DST_LO];
    assign bus.source_1        = field_reg[SRC1_HI:SRC1_LO];
    assign bus.source_2        = field_reg[SRC2_HI:SRC2_LO];
    assign bus.unsigned_1      = field_reg[2:0];
    assign bus.unsigned_2      = field_reg[5:0];
    assign bus.unsigned_3      = field_reg[8:0];
endmodule

// File: tb/tb_instruction_decode.sv
// Directed vector table for the decode stage, then randomized traffic checked
// against a behavioural model of the decode rules.
module tb_instruction_decode;
    logic clock = 1'b0;
    logic reset;
    logic flush;
    logic stall;

    instruction_decode_if bus ();

    instruction_decode dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .stall (stall),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        r, f, s, v;
        logic [15:0] w, pc;
        logic        rdy, dv;
        logic [5:0]  op;
        logic        ill;
        logic [15:0] dpc;
        logic [8:0]  fw;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic        m_dv, m_ill, m_pend;
    logic [5:0]  m_op;
    logic [15:0] m_pc, m_ppc;
    logic [8:0]  m_fw;

    function automatic vec_t mkv(int r, int f, int s, int v, int w, int pc,
                                 int rdy, int dv, int op, int ill, int dpc, int fw);
        vec_t t;
        t.r = r[0]; t.f = f[0]; t.s = s[0]; t.v = v[0];
        t.w = w[15:0]; t.pc = pc[15:0];
        t.rdy = rdy[0]; t.dv = dv[0]; t.op = op[5:0]; t.ill = ill[0];
        t.dpc = dpc[15:0]; t.fw = fw[8:0];
        return t;
    endfunction

    function automatic logic [50:0] pack(logic dv, logic [5:0] op, logic ill,
                                         logic [15:0] pc, logic [8:0] fw);
        return {dv, op, ill, pc, fw[8:6], fw[5:3], fw[2:0], fw[2:0], fw[5:0], fw};
    endfunction

    function automatic logic [50:0] dut_pack();
        return {bus.dec_valid, bus.operationnumber, bus.illegal, bus.dec_pc,
                bus.destination, bus.source_1, bus.source_2,
                bus.unsigned_1, bus.unsigned_2, bus.unsigned_3};
    endfunction

    task automatic check(input string name, input logic [50:0] act, input logic [50:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        reset           = t.r;
        flush           = t.f;
        stall           = t.s;
        bus.instr_valid = t.v;
        bus.instr_word  = t.w;
        bus.instr_pc    = t.pc;
    endtask

    task automatic ref_decode(input logic [15:0] w, output logic [5:0] op, output logic ill);
        int cls, opc;
        cls = (int'(w) / 8192) % 4;
        opc = (int'(w) / 512) % 16;
        op  = 6'd0;
        ill = 1'b0;
        if (cls == 0)                  op = 6'(opc);
        else if (cls == 1 && opc == 0) op = 6'd16;
        else if (cls == 1 && opc == 4) op = 6'd17;
        else                           ill = 1'b1;
    endtask

    task automatic model_edge();
        if (reset) begin
            m_dv = 0; m_op = 0; m_ill = 0; m_pc = 0; m_fw = 0; m_pend = 0; m_ppc = 0;
        end else if (flush) begin
            m_dv = 0; m_op = 0; m_ill = 0; m_pend = 0;
        end else if (!stall) begin
            m_dv = 0; m_op = 0; m_ill = 0;
            if (bus.instr_valid) begin
                if (m_pend) begin
                    m_dv = 1; m_ill = 1; m_pc = m_ppc; m_fw = bus.instr_word[8:0]; m_pend = 0;
                end else if (bus.instr_word[15]) begin
                    m_pend = 1; m_ppc = bus.instr_pc;
                end else begin
                    ref_decode(bus.instr_word, m_op, m_ill);
                    m_dv = 1; m_pc = bus.instr_pc; m_fw = bus.instr_word[8:0];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        m_dv = 0; m_op = 0; m_ill = 0; m_pc = 0; m_fw = 0; m_pend = 0; m_ppc = 0;
        //                r f s v  word     pc      rdy dv op ill dpc     fields
        vecs.push_back(mkv(1,0,0,0, 'h0000, 'h0000, 0,0, 0,0, 'h0000, 'h000));
        vecs.push_back(mkv(0,0,0,1, 'h02CA, 'h0010, 1,1, 1,0, 'h0010, 'h0CA));
        vecs.push_back(mkv(0,0,0,1, 'h1F6A, 'h0011, 1,1,15,0, 'h0011, 'h16A));
        vecs.push_back(mkv(0,0,0,0, 'h0000, 'h0000, 1,0, 0,0, 'h0011, 'h16A));
        vecs.push_back(mkv(0,0,0,1, 'h28A1, 'h0012, 1,1,17,0, 'h0012, 'h0A1));
        vecs.push_back(mkv(0,0,0,1, 'h4000, 'h0013, 1,1, 0,1, 'h0013, 'h000));
        vecs.push_back(mkv(0,0,0,1, 'h8000, 'h0020, 1,0, 0,0, 'h0013, 'h000));
        vecs.push_back(mkv(0,0,0,1, 'h8000, 'h0021, 1,1, 0,1, 'h0020, 'h000));
        vecs.push_back(mkv(0,0,0,1, 'h02CA, 'h0030, 1,1, 1,0, 'h0030, 'h0CA));
        vecs.push_back(mkv(0,0,1,1, 'h1F6A, 'h0031, 0,1, 1,0, 'h0030, 'h0CA));
        vecs.push_back(mkv(0,0,1,1, 'h1F6A, 'h0031, 0,1, 1,0, 'h0030, 'h0CA));
        vecs.push_back(mkv(0,0,1,1, 'h1F6A, 'h0031, 0,1, 1,0, 'h0030, 'h0CA));
        vecs.push_back(mkv(0,0,0,1, 'h1F6A, 'h0031, 1,1,15,0, 'h0031, 'h16A));
        vecs.push_back(mkv(0,0,0,1, 'h8000, 'h0040, 1,0, 0,0, 'h0031, 'h16A));
        vecs.push_back(mkv(0,1,0,1, 'h8000, 'h0041, 0,0, 0,0, 'h0031, 'h16A));
        vecs.push_back(mkv(0,0,0,1, 'h02CA, 'h0042, 1,1, 1,0, 'h0042, 'h0CA));
        vecs.push_back(mkv(0,0,0,1, 'h8000, 'h0050, 1,0, 0,0, 'h0042, 'h0CA));
        vecs.push_back(mkv(1,0,0,1, 'h02CA, 'h0051, 0,0, 0,0, 'h0000, 'h000));
        vecs.push_back(mkv(0,0,0,1, 'h02CA, 'h0051, 1,1, 1,0, 'h0051, 'h0CA));
        vecs.push_back(mkv(0,0,0,1, 'h8000, 'h0060, 1,0, 0,0, 'h0051, 'h0CA));
        vecs.push_back(mkv(0,0,0,0, 'h0000, 'h0000, 1,0, 0,0, 'h0051, 'h0CA));
        vecs.push_back(mkv(0,0,0,1, 'h1234, 'h0061, 1,1, 0,1, 'h0060, 'h034));
        vecs.push_back(mkv(0,0,0,1, 'h2200, 'h0062, 1,1, 0,1, 'h0062, 'h000));
        vecs.push_back(mkv(0,0,0,1, 'h2000, 'h0063, 1,1,16,0, 'h0063, 'h000));
        vecs.push_back(mkv(0,0,0,1, 'h6000, 'h0064, 1,1, 0,1, 'h0064, 'h000));
        vecs.push_back(mkv(0,0,0,1, 'h8000, 'h0070, 1,0, 0,0, 'h0064, 'h000));
        vecs.push_back(mkv(0,0,1,1, 'h0000, 'h0071, 0,0, 0,0, 'h0064, 'h000));
        vecs.push_back(mkv(0,0,0,1, 'h0000, 'h0072, 1,1, 0,1, 'h0070, 'h000));
        vecs.push_back(mkv(0,0,0,1, 'h02CA, 'h0080, 1,1, 1,0, 'h0080, 'h0CA));
        vecs.push_back(mkv(0,1,1,1, 'h1F6A, 'h0081, 0,0, 0,0, 'h0080, 'h0CA));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d_ready", i), {50'b0, bus.instr_ready}, {50'b0, vecs[i].rdy});
            tick();
            check($sformatf("vec%0d_out", i), dut_pack(),
                  pack(vecs[i].dv, vecs[i].op, vecs[i].ill, vecs[i].dpc, vecs[i].fw));
            $display("vec %0d: word=%h pc=%h -> dv=%b op=%0d ill=%b dpc=%h",
                     i, vecs[i].w, vecs[i].pc, bus.dec_valid, bus.operationnumber,
                     bus.illegal, bus.dec_pc);
        end

        for (int n = 0; n < 300; n++) begin
            vec_t t;
            t = mkv(0,0,0,0, 0,0, 0,0,0,0,0,0);
            t.r  = ($urandom_range(63) == 0);
            t.f  = ($urandom_range(9) == 0);
            t.s  = ($urandom_range(4) == 0);
            t.v  = ($urandom_range(3) != 0);
            t.w  = 16'($urandom_range(65535));
            t.pc = 16'($urandom_range(65535));
            drive(t);
            #1;
            check($sformatf("rnd%0d_ready", n), {50'b0, bus.instr_ready},
                  {50'b0, (!t.r && !t.f && !t.s)});
            tick();
            check($sformatf("rnd%0d_out", n), dut_pack(), pack(m_dv, m_op, m_ill, m_pc, m_fw));
            $display("rnd %0d: r=%b f=%b s=%b v=%b word=%h -> dv=%b op=%0d ill=%b dpc=%h",
                     n, t.r, t.f, t.s, t.v, t.w, bus.dec_valid, bus.operationnumber,
                     bus.illegal, bus.dec_pc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
